spi_byte_receiver: RTL



---
 rtl/spi_rx_pkg.sv | 19 +
 rtl/spi_rx_fifo.sv | 54 +++++
 rtl/spi_byte_receiver.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/spi_rx_pkg.sv
// rtl/spi_rx_pkg.sv - shared widths, constants and shift helper for the SPI byte receiver
package spi_rx_pkg;

  localparam int BYTE_W   = 8;
  localparam int BITCNT_W = 3;

  // Value shifted out on MISO when the host has no reply byte queued.
  localparam logic [BYTE_W-1:0] IDLE_FILL = 8'hFF;

  // Bit index of the last bit in a frame (counter wraps after it).
  localparam logic [BITCNT_W-1:0] BIT_LAST = '1;

  // MSB-first shift: drop the top bit, append the new bit at the bottom.
  function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] cur,
                                                  input logic              bit_in);
    return {cur[BYTE_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// rtl/spi_rx_fifo.sv - synchronous byte FIFO with registered-pointer head read
module spi_rx_fifo
  import spi_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [BYTE_W-1:0]       push_data,
  input  logic                    pop,
  output logic [BYTE_W-1:0]       head_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [IDX_W:0]    wr_ptr;
  logic [IDX_W:0]    rd_ptr;
  logic              wr_en;
  logic              rd_en;

  // Status flags from the extra pointer bit; a write into a full FIFO is
  // allowed only when a read frees the head slot in the same cycle.
  always_comb begin
    count     = wr_ptr - rd_ptr;
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    rd_en     = pop & ~empty;
    wr_en     = push & (~full | rd_en);
    head_data = mem[rd_ptr[IDX_W-1:0]];
  end

  // Pointer advance; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/spi_byte_receiver.sv
// rtl/spi_byte_receiver.sv - SPI peripheral endpoint: MOSI deserializer, byte FIFO, MISO reply shifter
module spi_byte_receiver
  import spi_rx_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    IN_SPI_clk,
  input  logic                    IN_SPI_mosi,
  output logic                    OUT_SPI_miso,
  output logic [BYTE_W-1:0]       OUT_data,
  output logic                    OUT_valid,
  input  logic                    IN_ready,
  output logic [$clog2(DEPTH):0]  OUT_count,
  output logic                    OUT_overflow,
  input  logic                    IN_clrOverflow,
  output logic                    OUT_frameErr,
  input  logic [BYTE_W-1:0]       IN_txByte,
  input  logic                    IN_txValid,
  output logic                    OUT_txReady
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  // Sampled pins and edge detect
  logic sclk_q;
  logic sclk_p;
  logic mosi_q;
  logic rise;
  logic fall;

  // Receive state
  logic [BITCNT_W-1:0] bit_cnt;
  logic [BYTE_W-1:0]   rx_shift;
  logic [IDLE_W-1:0]   idle_cnt;
  logic                timeout;
  logic                frame_start;

  // FIFO interface
  logic                push;
  logic [BYTE_W-1:0]   push_data;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;

  // Transmit state
  logic [BYTE_W-1:0]   tx_hold;
  logic                tx_full;
  logic [BYTE_W-1:0]   tx_shift;
  logic                tx_load;

  // Status registers
  logic                overflow;
  logic                frame_err;

  // Register SCLK/MOSI once and keep the previous SCLK for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= 1'b0;
      sclk_p <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      sclk_q <= IN_SPI_clk;
      sclk_p <= sclk_q;
      mosi_q <= IN_SPI_mosi;
    end
  end

  // Edge strobes, frame events and the idle-timeout condition; a rise in
  // the timeout cycle wins so a late-but-valid clock is never discarded.
  always_comb begin
    rise        = sclk_q & ~sclk_p;
    fall        = ~sclk_q & sclk_p;
    frame_start = rise && (bit_cnt == '0);
    push        = rise && (bit_cnt == BIT_LAST);
    push_data   = shift_in(rx_shift, mosi_q);
    timeout     = !rise && (bit_cnt != '0) && (idle_cnt == IDLE_LAST);
    pop         = OUT_valid & IN_ready;
    tx_load     = IN_txValid & ~tx_full;
  end

  // Deserializer: shift on each rise, abandon a partial frame on timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else if (rise) begin
      rx_shift <= push_data;
      bit_cnt  <= bit_cnt + 1'b1;
    end else if (timeout) begin
      rx_shift <= '0;
      bit_cnt  <= '0;
    end
  end

  // Idle counter: held at zero between frames, saturates mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (rise || (bit_cnt == '0)) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_LAST) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // One-cycle frame error pulse, registered from the timeout condition.
  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= timeout;
  end

  // Sticky overflow: set when a push is refused; setting beats clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end else if (IN_clrOverflow) begin
      overflow <= 1'b0;
    end
  end

  // Reply holding register; a byte loaded at frame start waits for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_hold <= '0;
      tx_full <= 1'b0;
    end else if (tx_load) begin
      tx_hold <= IN_txByte;
      tx_full <= 1'b1;
    end else if (frame_start) begin
      tx_full <= 1'b0;
    end
  end

  // MISO shifter: load at frame start, advance on each fall, idle fill otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift <= IDLE_FILL;
    end else if (frame_start) begin
      tx_shift <= tx_full ? tx_hold : IDLE_FILL;
    end else if (fall) begin
      tx_shift <= shift_in(tx_shift, 1'b1);
    end else if (timeout) begin
      tx_shift <= IDLE_FILL;
    end
  end

  spi_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (OUT_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (OUT_count)
  );

  // Output mapping
  always_comb begin
    OUT_valid    = ~fifo_empty;
    OUT_SPI_miso = tx_shift[BYTE_W-1];
    OUT_overflow = overflow;
    OUT_frameErr = frame_err;
    OUT_txReady  = ~tx_full;
  end

endmodule
